// File: rtl/matmul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matmul_pkg : state encoding and flat-bus index helper for the host   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package matmul_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_LOAD_A = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD_B = 3'd1;
  localparam logic [ST_W-1:0] ST_FIRE   = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT   = 3'd3;
  localparam logic [ST_W-1:0] ST_DRAIN  = 3'd4;

  // LSB of row-major element (i,j) in a flat bus of w-bit elements
  function automatic int elem_lsb(input int i, input int j, input int cols, input int w);
    return (i * cols + j) * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_stream_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matmul_stream_host : packs a serial A/B stream into flat core buses, |
// | pulses cen once per job and streams flat C back out.   rev 1.0       |
// +----------------------------------------------------------------------+
module matmul_stream_host
  import matmul_pkg::*;
#(
  parameter int R1     = 2,
  parameter int C1     = 2,
  parameter int R2     = 2,
  parameter int C2     = 2,
  parameter int W_A    = 3,
  parameter int W_B    = 3,
  parameter int W_C    = W_A + W_B + $clog2(C1),
  parameter int W_IN   = (W_A > W_B) ? W_A : W_B,
  parameter int MM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W_IN-1:0]        s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [W_C-1:0]         m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   cen,
  output logic [R1*C1*W_A-1:0]   a_out,
  output logic [R2*C2*W_B-1:0]   b_out,
  input  logic [R1*C2*W_C-1:0]   c_in,
  output logic                   busy
);

  localparam int N_A   = R1 * C1;
  localparam int N_B   = R2 * C2;
  localparam int N_C   = R1 * C2;
  localparam int N_MAX = (N_A > N_B) ? ((N_A > N_C) ? N_A : N_C) : ((N_B > N_C) ? N_B : N_C);
  localparam int IDX_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int LAT_W = (MM_LAT > 1) ? $clog2(MM_LAT) : 1;

  localparam logic [IDX_W-1:0] IDX_A_LAST = IDX_W'(N_A - 1);
  localparam logic [IDX_W-1:0] IDX_B_LAST = IDX_W'(N_B - 1);
  localparam logic [IDX_W-1:0] IDX_C_LAST = IDX_W'(N_C - 1);
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(MM_LAT - 1);

  if (C1 != R2) begin : g_bad_dims
    $error("matmul_stream_host: C1 (%0d) must equal R2 (%0d)", C1, R2);
  end
  if (MM_LAT < 1) begin : g_bad_lat
    $error("matmul_stream_host: MM_LAT must be at least 1");
  end

  logic [ST_W-1:0]        state_q, state_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [LAT_W-1:0]       lat_q,   lat_d;
  logic [N_A*W_A-1:0]     a_q,     a_d;
  logic [N_B*W_B-1:0]     b_q,     b_d;
  logic [N_C*W_C-1:0]     c_q,     c_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD_A;
      idx_q   <= '0;
      lat_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  // s_ready is unconditionally high in both LOAD states, so s_valid alone marks a beat
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    case (state_q)
      ST_LOAD_A: if (s_valid) begin
        a_d[elem_lsb(0, int'(idx_q), N_A, W_A) +: W_A] = s_data[W_A-1:0];
        if (idx_q == IDX_A_LAST) begin
          idx_d   = '0;
          state_d = ST_LOAD_B;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_LOAD_B: if (s_valid) begin
        b_d[elem_lsb(0, int'(idx_q), N_B, W_B) +: W_B] = s_data[W_B-1:0];
        if (idx_q == IDX_B_LAST) begin
          idx_d   = '0;
          state_d = ST_FIRE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_FIRE: begin
        lat_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_LAST) begin
          c_d     = c_in;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (m_ready) begin
        if (idx_q == IDX_C_LAST) begin
          idx_d   = '0;
          state_d = ST_LOAD_A;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    s_ready = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    m_valid = (state_q == ST_DRAIN);
    m_last  = m_valid && (idx_q == IDX_C_LAST);
    cen     = (state_q == ST_FIRE);
    busy    = !((state_q == ST_LOAD_A) && (idx_q == '0));
    m_data  = c_q[elem_lsb(0, int'(idx_q), N_C, W_C) +: W_C];
  end

  assign a_out = a_q;
  assign b_out = b_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_stream_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_matmul_stream_host : random and directed jobs through the host    |
// | with a behavioural core attached, scored against A*B.   rev 1.0      |
// +----------------------------------------------------------------------+
module tb_matmul_stream_host;

  localparam int R1 = 2, C1 = 2, R2 = 2, C2 = 2;
  localparam int W_A = 3, W_B = 3, W_C = 7, W_IN = 3, MM_LAT = 1;
  localparam int NA = R1 * C1, NB = R2 * C2, NC = R1 * C2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [W_IN-1:0]      s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [W_C-1:0]       m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;
  logic                 cen;
  logic [NA*W_A-1:0]    a_out;
  logic [NB*W_B-1:0]    b_out;
  logic [NC*W_C-1:0]    c_in = '0;
  logic                 busy;

  matmul_stream_host #(
    .R1(R1), .C1(C1), .R2(R2), .C2(C2),
    .W_A(W_A), .W_B(W_B), .W_C(W_C), .W_IN(W_IN), .MM_LAT(MM_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .cen(cen), .a_out(a_out), .b_out(b_out), .c_in(c_in), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W_C-1:0] d;
    bit             last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0, n_out = 0, cyc = 0;
  int   bp_mode = 0, ph = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural core with one cycle of latency from cen
  always @(posedge clk) begin : core_model
    logic [NC*W_C-1:0] tmp;
    int acc;
    if (cen) begin
      tmp = '0;
      for (int i = 0; i < R1; i++)
        for (int j = 0; j < C2; j++) begin
          acc = 0;
          for (int k = 0; k < C1; k++)
            acc += int'(a_out[(i*C1+k)*W_A +: W_A]) * int'(b_out[(k*C2+j)*W_B +: W_B]);
          tmp[(i*C2+j)*W_C +: W_C] = W_C'(acc);
        end
      c_in <= tmp;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       m_ready = 1'b1;
        1:       begin m_ready = (ph % 3 == 0); ph++; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pops, handshake timing, hold-under-stall, busy between jobs
  int             beat_cnt = 0, last_b = -100;
  bit             stall = 0, mv_prev = 0, idle_chk = 0;
  logic [W_C-1:0] held_d;
  logic           held_l;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      beat_cnt = 0; stall = 0; mv_prev = 0; idle_chk = 0;
    end else begin
      if (s_valid && s_ready) begin
        beat_cnt++;
        if (beat_cnt == NA + NB) begin
          beat_cnt = 0;
          last_b   = cyc;
        end
      end
      if (cen) check("cen_one_after_last_b", cyc, last_b + 1);
      if (m_valid && !mv_prev) check("first_m_valid_latency", cyc, last_b + 2 + MM_LAT);
      if (idle_chk) begin
        check("busy_low_between_jobs", busy, 0);
        idle_chk = 0;
      end
      if (stall) begin
        check("stall_hold_valid", m_valid, 1);
        check("stall_hold_data", m_data, held_d);
        check("stall_hold_last", m_last, held_l);
      end
      if (m_valid) begin
        check("s_ready_low_in_drain", s_ready, 0);
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_output: got %0d expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            check("m_data", m_data, e.d);
            check("m_last", m_last, e.last);
          end
          n_out++;
          if (m_last) idle_chk = 1;
        end
      end
      stall   = m_valid && !m_ready;
      held_d  = m_data;
      held_l  = m_last;
      mv_prev = m_valid;
    end
  end

  // All driver tasks start and end at posedge+1
  task automatic send_beat(input int v, input int gap);
    int n = 0;
    s_valid = 1'b1;
    s_data  = W_IN'(v);
    @(negedge clk);
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    if (!s_ready) check("s_ready_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_job(input int a[NA], input int b[NB], input int gap);
    exp_t e;
    int   s;
    for (int i = 0; i < R1; i++)
      for (int j = 0; j < C2; j++) begin
        s = 0;
        for (int k = 0; k < C1; k++) s += a[i*C1+k] * b[k*C2+j];
        e.d    = W_C'(s);
        e.last = (i == R1 - 1) && (j == C2 - 1);
        exp_q.push_back(e);
      end
    for (int k = 0; k < NA; k++) send_beat(a[k], gap);
    for (int k = 0; k < NB; k++) send_beat(b[k], gap);
  endtask

  task automatic wait_out(input int target);
    int n = 0;
    while (n_out < target && n < 400) begin @(posedge clk); #1; n++; end
    if (n_out < target) check("drain_timeout", n_out, target);
  endtask

  task automatic run_job(input int a[NA], input int b[NB], input int gap);
    int start = n_out;
    send_job(a, b, gap);
    wait_out(start + NC);
  endtask

  int a_v[NA], b_v[NB];

  task automatic rand_mats();
    for (int k = 0; k < NA; k++) a_v[k] = int'($urandom_range(0, 7));
    for (int k = 0; k < NB; k++) b_v[k] = int'($urandom_range(0, 7));
  endtask

  initial begin
    int start;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_cen", cen, 0);
    check("rst_busy", busy, 0);
    check("rst_a_out", a_out, 0);
    check("rst_b_out", b_out, 0);
    @(posedge clk); #1;

    a_v = '{1, 2, 3, 4}; b_v = '{5, 6, 7, 0};
    run_job(a_v, b_v, 0);

    a_v = '{7, 7, 7, 7}; b_v = '{7, 7, 7, 7};
    run_job(a_v, b_v, 0);

    bp_mode = 1; ph = 0;
    rand_mats();
    run_job(a_v, b_v, 0);
    bp_mode = 0;

    a_v = '{1, 2, 3, 4}; b_v = '{5, 6, 7, 0};
    run_job(a_v, b_v, 1);

    // Abort a job two outputs into the drain
    rand_mats();
    start = n_out;
    send_job(a_v, b_v, 0);
    wait_out(start + 2);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_cen", cen, 0);
    @(posedge clk); #1;
    rand_mats();
    run_job(a_v, b_v, 0);

    a_v = '{1, 2, 3, 4}; b_v = '{5, 6, 7, 0};
    run_job(a_v, b_v, 0);
    b_v = '{1, 0, 0, 1};
    run_job(a_v, b_v, 0);

    bp_mode = 2;
    for (int j = 0; j < 6; j++) begin
      rand_mats();
      run_job(a_v, b_v, 2);
    end
    bp_mode = 0;

    repeat (5) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
